// File: rtl/ula_writeback.sv
// ula_writeback: ULA writeback stage with flag register, 2-entry write buffer and stall counter
module ula_writeback #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_result,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_flag_en,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags,
    output logic [STALL_W-1:0] stall_cnt
);
    logic [1:0]        count;
    logic [ADDR_W-1:0] tail_addr;
    logic [DATA_W-1:0] tail_data;
    logic [DATA_W-1:0] x, y;
    logic              cin, arith, c_flag, v_flag;
    logic [DATA_W:0]   sum;
    logic [1:0]        count_next;
    logic              accept, push, pop;

    assign in_ready   = count < 2'd2;
    assign accept     = in_valid & in_ready;
    assign push       = accept & in_wr_en & (in_dest != '0);
    assign pop        = wb_valid & wb_ready;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // Rebuild the adder inputs implied by the opcode and derive carry/overflow
    always_comb begin
        x     = in_a;
        y     = in_b;
        cin   = 1'b0;
        arith = 1'b1;
        case (in_opcode)
            5'b00000: begin y = in_b;    cin = 1'b0; end
            5'b00001: begin y = in_b;    cin = 1'b1; end
            5'b00011: begin y = '0;      cin = 1'b1; end
            5'b00101: begin y = ~in_b;   cin = 1'b1; end
            5'b00100: begin y = ~in_b;   cin = 1'b0; end
            5'b00110: begin y = '1;      cin = 1'b0; end
            default:  arith = 1'b0;
        endcase
        sum    = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
        c_flag = arith ? sum[DATA_W] :
                 (in_opcode == 5'b01000) ? in_a[DATA_W-1] :
                 (in_opcode == 5'b01001) ? in_a[0] : 1'b0;
        v_flag = arith ? ((x[DATA_W-1] == y[DATA_W-1]) & (sum[DATA_W-1] != x[DATA_W-1])) :
                 (in_opcode == 5'b01000) ? (in_a[DATA_W-1] ^ in_a[DATA_W-2]) : 1'b0;
    end

    // Flag register loads on every accepted flag-updating op
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            flags <= 4'b0000;
        else if (accept && in_flag_en)
            flags <= {in_result[DATA_W-1], in_result == '0, c_flag, v_flag};
    end

    // Two-slot FIFO: head lives directly in the wb_addr/wb_data output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= 2'd0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            tail_addr <= '0;
            tail_data <= '0;
        end else begin
            count    <= count_next;
            wb_valid <= count_next != 2'd0;
            if (pop && count == 2'd2) begin
                wb_addr <= tail_addr;
                wb_data <= tail_data;
            end else if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                wb_addr <= in_dest;
                wb_data <= in_result;
            end
            if (push && count == 2'd1 && !pop) begin
                tail_addr <= in_dest;
                tail_data <= in_result;
            end
        end
    end

    // Saturating count of cycles where a pending write is refused
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (wb_valid && !wb_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ula_writeback.sv
// tb_ula_writeback: directed self-checking bench for ula_writeback
module tb_ula_writeback;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [31:0] in_a = '0, in_b = '0, in_result = '0;
    logic [4:0]  in_dest = '0;
    logic        in_wr_en = 1'b0, in_flag_en = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic [15:0] stall_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    ula_writeback dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_result(in_result),
        .in_dest(in_dest), .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .flags(flags), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [4:0] dest, input logic wr, input logic fl);
        in_valid = 1'b1; in_opcode = opc; in_a = a; in_b = b; in_result = res;
        in_dest = dest; in_wr_en = wr; in_flag_en = fl;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b want 0000", flags); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
        n_cmp++; if ({wb_addr, wb_data} !== 37'd0) begin n_bad++; $display("FAIL rst_wb_head got %h/%h want 0/0", wb_addr, wb_data); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_add_overflow();
        wb_ready = 1'b1;
        op(5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 5'd3, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (flags !== 4'b1001) begin n_bad++; $display("FAIL add_ovf_flags got %b want 1001", flags); end
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL add_ovf_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_data !== 32'h80000000) begin n_bad++; $display("FAIL add_ovf_data got %h want 80000000", wb_data); end
        n_cmp++; if (wb_addr !== 5'd3) begin n_bad++; $display("FAIL add_ovf_addr got %0d want 3", wb_addr); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL add_ovf_drained got %b want 0", wb_valid); end
    endtask

    task automatic test_flag_rules();
        logic [4:0]  opc [10] = '{5'b00000, 5'b00101, 5'b00100, 5'b00001, 5'b01000,
                                 5'b01001, 5'b00011, 5'b00110, 5'b10000, 5'b00101};
        logic [31:0] a   [10] = '{32'hFFFFFFFF, 32'd5, 32'd0, 32'd1, 32'h40000000,
                                 32'h80000001, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd3};
        logic [31:0] b   [10] = '{32'd1, 32'd5, 32'd0, 32'd1, 32'd0,
                                 32'd1, 32'd0, 32'd0, 32'd1, 32'd5};
        logic [31:0] r   [10] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd3, 32'h80000000,
                                 32'hC0000000, 32'd0, 32'h7FFFFFFF, 32'd1, 32'hFFFFFFFE};
        logic [3:0]  exp [10] = '{4'b0110, 4'b0110, 4'b1000, 4'b0000, 4'b1001,
                                 4'b1010, 4'b0110, 4'b0011, 4'b0000, 4'b1000};
        for (int i = 0; i < 10; i++) begin
            op(opc[i], a[i], b[i], r[i], 5'd0, 1'b0, 1'b1);
            tick();
            n_cmp++; if (flags !== exp[i]) begin n_bad++; $display("FAIL flags_vec%0d op=%b got %b want %b", i, opc[i], flags, exp[i]); end
        end
        in_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flag_vec_nowrite got %b want 0", wb_valid); end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        op(5'b10000, 0, 0, 32'h11, 5'd1, 1'b1, 1'b0);
        tick();
        n_cmp++; if (in_ready !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== 5'd1) begin n_bad++; $display("FAIL bp_first rdy=%b val=%b addr=%0d want 1/1/1", in_ready, wb_valid, wb_addr); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL bp_stall0 got %0d want 0", stall_cnt); end
        op(5'b10000, 0, 0, 32'h22, 5'd2, 1'b1, 1'b0);
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL bp_stall1 got %0d want 1", stall_cnt); end
        op(5'b10000, 0, 0, 32'h33, 5'd3, 1'b1, 1'b0);
        tick();
        n_cmp++; if (in_ready !== 1'b0 || wb_addr !== 5'd1) begin n_bad++; $display("FAIL bp_held rdy=%b addr=%0d want 0/1", in_ready, wb_addr); end
        n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL bp_stall2 got %0d want 2", stall_cnt); end
        tick();
        n_cmp++; if (stall_cnt !== 16'd3 || wb_data !== 32'h11) begin n_bad++; $display("FAIL bp_stall3 cnt=%0d data=%h want 3/11", stall_cnt, wb_data); end
        wb_ready = 1'b1;
        tick();
        n_cmp++; if (wb_addr !== 5'd2 || wb_data !== 32'h22 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_drain1 addr=%0d data=%h rdy=%b want 2/22/1", wb_addr, wb_data, in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (wb_addr !== 5'd3 || wb_data !== 32'h33 || wb_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain2 addr=%0d data=%h val=%b want 3/33/1", wb_addr, wb_data, wb_valid); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0 || stall_cnt !== 16'd3) begin n_bad++; $display("FAIL bp_empty val=%b stall=%0d want 0/3", wb_valid, stall_cnt); end
    endtask

    task automatic test_filtering();
        op(5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 5'd5, 1'b0, 1'b1);
        tick();
        n_cmp++; if (flags !== 4'b1001 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL filt_nowr flags=%b val=%b want 1001/0", flags, wb_valid); end
        op(5'b00101, 32'd5, 32'd5, 32'd0, 5'd0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (flags !== 4'b1001 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL filt_r0_noflag flags=%b val=%b want 1001/0", flags, wb_valid); end
        op(5'b00101, 32'd5, 32'd5, 32'd0, 5'd0, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (flags !== 4'b0110 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL filt_r0_flag flags=%b val=%b want 0110/0", flags, wb_valid); end
    endtask

    task automatic test_streaming();
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op(5'b10000, 0, 0, 32'h101 * (i + 1), 5'(i + 1), 1'b1, 1'b0);
            tick();
            n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'(i + 1) || wb_data !== 32'h101 * (i + 1) || in_ready !== 1'b1)
            begin n_bad++; $display("FAIL stream%0d val=%b addr=%0d data=%h rdy=%b want 1/%0d/%h/1", i, wb_valid, wb_addr, wb_data, in_ready, i + 1, 32'h101 * (i + 1)); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (wb_valid !== 1'b0 || stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stream_end val=%b stall=%0d want 0/3", wb_valid, stall_cnt); end
    endtask

    task automatic test_reset_midstream();
        wb_ready = 1'b0;
        op(5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 5'd7, 1'b1, 1'b1);
        tick();
        op(5'b10000, 0, 0, 32'h99, 5'd8, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b0 || stall_cnt === 16'd0) begin n_bad++; $display("FAIL mid_prefill rdy=%b stall=%0d want 0/nonzero", in_ready, stall_cnt); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_q val=%b rdy=%b want 0/1", wb_valid, in_ready); end
        n_cmp++; if (flags !== 4'b0000 || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_regs flags=%b stall=%0d want 0000/0", flags, stall_cnt); end
        tick();
        reset_n = 1'b1;
        wb_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 32'd0) begin n_bad++; $display("FAIL mid_no_stale val=%b data=%h want 0/0", wb_valid, wb_data); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_flag_rules();
        test_backpressure();
        test_filtering();
        test_streaming();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
